rop_dcr_sched: RTL

Configuration scheduler for the ROP unit. It captures DCR writes into a staging copy of the ROP state (`rop_dcrs_t`) and tracks fragments in flight through the ROP datapath. On a commit it gates new fragment admission, waits until the datapath drains, then swaps staging into the active configuration the datapath reads. It sits between the DCR bus and the ROP request front-end, so no fragment is ever processed under a half-updated configuration.

---
 rtl/VX_rop_types.sv | 102 ++++++++++
 rtl/rop_dcr_decode.sv | 68 ++++++
 rtl/rop_dcr_sched.sv | 113 +++++++++++
 3 files changed

// File: rtl/VX_rop_types.sv
// VX_rop_types: ROP DCR map, configuration layout and scheduler states.
// Packed field order follows the DCR word packing (first field is the MSB).
package VX_rop_types;

   localparam int ROP_DCR_ADDR_BITS = 4;
   localparam int ROP_STENCIL_BITS  = 6;

   localparam logic [ROP_DCR_ADDR_BITS-1:0] DCR_CBUF_ADDR      = 4'd0;
   localparam logic [ROP_DCR_ADDR_BITS-1:0] DCR_CBUF_PITCH     = 4'd1;
   localparam logic [ROP_DCR_ADDR_BITS-1:0] DCR_CBUF_WRITEMASK = 4'd2;
   localparam logic [ROP_DCR_ADDR_BITS-1:0] DCR_ZBUF_ADDR      = 4'd3;
   localparam logic [ROP_DCR_ADDR_BITS-1:0] DCR_ZBUF_PITCH     = 4'd4;
   localparam logic [ROP_DCR_ADDR_BITS-1:0] DCR_DEPTH          = 4'd5;
   localparam logic [ROP_DCR_ADDR_BITS-1:0] DCR_STENCIL_FRONT  = 4'd6;
   localparam logic [ROP_DCR_ADDR_BITS-1:0] DCR_STENCIL_BACK   = 4'd7;
   localparam logic [ROP_DCR_ADDR_BITS-1:0] DCR_BLEND_MODE     = 4'd8;
   localparam logic [ROP_DCR_ADDR_BITS-1:0] DCR_BLEND_FUNC     = 4'd9;
   localparam logic [ROP_DCR_ADDR_BITS-1:0] DCR_BLEND_CONST    = 4'd10;
   localparam logic [ROP_DCR_ADDR_BITS-1:0] DCR_LOGIC_OP       = 4'd11;
   localparam logic [ROP_DCR_ADDR_BITS-1:0] DCR_COMMIT         = 4'd12;

   localparam int DEPTH_EN_OFF      = 0;
   localparam int DEPTH_FUNC_OFF    = 1;
   localparam int DEPTH_WMASK_OFF   = 4;
   localparam int STENCIL_EN_OFF    = 0;
   localparam int STENCIL_FUNC_OFF  = 1;
   localparam int STENCIL_ZPASS_OFF = 4;
   localparam int STENCIL_ZFAIL_OFF = 7;
   localparam int STENCIL_FAIL_OFF  = 10;
   localparam int STENCIL_REF_OFF   = 13;
   localparam int STENCIL_MASK_OFF  = 19;
   localparam int STENCIL_WMASK_OFF = 25;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      APPLY
   } rop_sched_state_e;

   typedef struct packed {
      logic       writemask;
      logic [2:0] func;
      logic       enable;
   } rop_depth_t;

   typedef struct packed {
      logic [ROP_STENCIL_BITS-1:0] writemask;
      logic [ROP_STENCIL_BITS-1:0] mask;
      logic [ROP_STENCIL_BITS-1:0] sref;
      logic [2:0]                  fail;
      logic [2:0]                  zfail;
      logic [2:0]                  zpass;
      logic [2:0]                  func;
      logic                        enable;
   } rop_stencil_t;

   typedef struct packed {
      logic [2:0] alpha;
      logic [2:0] rgb;
   } rop_blend_mode_t;

   typedef struct packed {
      logic [3:0] dst_a;
      logic [3:0] dst_rgb;
      logic [3:0] src_a;
      logic [3:0] src_rgb;
   } rop_blend_func_t;

   typedef struct packed {
      logic [31:0]     cbuf_addr;
      logic [31:0]     cbuf_pitch;
      logic [3:0]      cbuf_writemask;
      logic [31:0]     zbuf_addr;
      logic [31:0]     zbuf_pitch;
      rop_depth_t      depth;
      rop_stencil_t    stencil_front;
      rop_stencil_t    stencil_back;
      rop_blend_mode_t blend_mode;
      rop_blend_func_t blend_func;
      logic [31:0]     blend_const;
      logic [3:0]      logic_op;
   } rop_dcrs_t;

   localparam int DEPTH_W   = $bits(rop_depth_t);
   localparam int STENCIL_W = $bits(rop_stencil_t);
   localparam int BMODE_W   = $bits(rop_blend_mode_t);
   localparam int BFUNC_W   = $bits(rop_blend_func_t);

   function automatic rop_dcrs_t rop_dcrs_reset();
      rop_dcrs_t v;
      v = '0;
      v.cbuf_writemask          = '1;
      v.stencil_front.mask      = '1;
      v.stencil_front.writemask = '1;
      v.stencil_back.mask       = '1;
      v.stencil_back.writemask  = '1;
      return v;
   endfunction

   localparam rop_dcrs_t ROP_DCRS_RESET = rop_dcrs_reset();

endpackage

// File: rtl/rop_dcr_decode.sv
// rop_dcr_decode: DCR word to staging-field update, plus optional readback.
// ROP_DCR_READBACK_EN adds the combinational staging readback mux.
module rop_dcr_decode
   import VX_rop_types::*;
(
   input  logic                         i_wr_en,
   input  logic [ROP_DCR_ADDR_BITS-1:0] i_wr_addr,
   input  logic [31:0]                  i_wr_data,
`ifdef ROP_DCR_READBACK_EN
   input  logic [ROP_DCR_ADDR_BITS-1:0] i_rd_addr,
   input  logic                         i_cfg_busy,
   output logic [31:0]                  o_rd_data,
`endif
   input  logic [$bits(rop_dcrs_t)-1:0] i_staging,
   output logic [$bits(rop_dcrs_t)-1:0] o_staging
);

   rop_dcrs_t w_cur;
   rop_dcrs_t w_nxt;

   assign w_cur     = rop_dcrs_t'(i_staging);
   assign o_staging = w_nxt;

   // COMMIT and unmapped addresses leave staging untouched
   always_comb begin
      w_nxt = w_cur;
      if (i_wr_en) begin
         case (i_wr_addr)
            DCR_CBUF_ADDR:      w_nxt.cbuf_addr      = i_wr_data;
            DCR_CBUF_PITCH:     w_nxt.cbuf_pitch     = i_wr_data;
            DCR_CBUF_WRITEMASK: w_nxt.cbuf_writemask = i_wr_data[3:0];
            DCR_ZBUF_ADDR:      w_nxt.zbuf_addr      = i_wr_data;
            DCR_ZBUF_PITCH:     w_nxt.zbuf_pitch     = i_wr_data;
            DCR_DEPTH:          w_nxt.depth          = i_wr_data[DEPTH_W-1:0];
            DCR_STENCIL_FRONT:  w_nxt.stencil_front  = i_wr_data[STENCIL_W-1:0];
            DCR_STENCIL_BACK:   w_nxt.stencil_back   = i_wr_data[STENCIL_W-1:0];
            DCR_BLEND_MODE:     w_nxt.blend_mode     = i_wr_data[BMODE_W-1:0];
            DCR_BLEND_FUNC:     w_nxt.blend_func     = i_wr_data[BFUNC_W-1:0];
            DCR_BLEND_CONST:    w_nxt.blend_const    = i_wr_data;
            DCR_LOGIC_OP:       w_nxt.logic_op       = i_wr_data[3:0];
            default: ;
         endcase
      end
   end

`ifdef ROP_DCR_READBACK_EN
   always_comb begin
      o_rd_data = '0;
      case (i_rd_addr)
         DCR_CBUF_ADDR:      o_rd_data                = w_cur.cbuf_addr;
         DCR_CBUF_PITCH:     o_rd_data                = w_cur.cbuf_pitch;
         DCR_CBUF_WRITEMASK: o_rd_data[3:0]           = w_cur.cbuf_writemask;
         DCR_ZBUF_ADDR:      o_rd_data                = w_cur.zbuf_addr;
         DCR_ZBUF_PITCH:     o_rd_data                = w_cur.zbuf_pitch;
         DCR_DEPTH:          o_rd_data[DEPTH_W-1:0]   = w_cur.depth;
         DCR_STENCIL_FRONT:  o_rd_data[STENCIL_W-1:0] = w_cur.stencil_front;
         DCR_STENCIL_BACK:   o_rd_data[STENCIL_W-1:0] = w_cur.stencil_back;
         DCR_BLEND_MODE:     o_rd_data[BMODE_W-1:0]   = w_cur.blend_mode;
         DCR_BLEND_FUNC:     o_rd_data[BFUNC_W-1:0]   = w_cur.blend_func;
         DCR_BLEND_CONST:    o_rd_data                = w_cur.blend_const;
         DCR_LOGIC_OP:       o_rd_data[3:0]           = w_cur.logic_op;
         DCR_COMMIT:         o_rd_data[0]             = i_cfg_busy;
         default: ;
      endcase
   end
`endif

endmodule

// File: rtl/rop_dcr_sched.sv
// rop_dcr_sched: staged ROP configuration, swapped in only once the datapath drains.
// ROP_DCR_READBACK_EN adds the dcr_rd_addr/dcr_rd_data staging readback port.
module rop_dcr_sched
   import VX_rop_types::*;
#(
   parameter int MAX_OUTSTANDING = 16,
   parameter int CNT_BITS        = $clog2(MAX_OUTSTANDING+1)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         dcr_wr_valid,
   output logic                         dcr_wr_ready,
   input  logic [ROP_DCR_ADDR_BITS-1:0] dcr_wr_addr,
   input  logic [31:0]                  dcr_wr_data,
`ifdef ROP_DCR_READBACK_EN
   input  logic [ROP_DCR_ADDR_BITS-1:0] dcr_rd_addr,
   output logic [31:0]                  dcr_rd_data,
`endif
   input  logic                         req_fire,
   input  logic                         rsp_fire,
   output logic                         admit_en,
   output logic [$bits(rop_dcrs_t)-1:0] dcrs,
   output logic                         cfg_busy,
   output logic                         commit_done
);

   localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_OUTSTANDING);

   rop_sched_state_e r_state;
   rop_sched_state_e w_state_nxt;

   logic [CNT_BITS-1:0] r_cnt;
   logic [CNT_BITS-1:0] w_cnt_nxt;

   rop_dcrs_t r_staging;
   rop_dcrs_t r_active;
   logic [$bits(rop_dcrs_t)-1:0] w_staging_nxt;

   logic r_busy;
   logic r_done;
   logic w_wr_en;
   logic w_commit;

   assign w_wr_en  = dcr_wr_valid && (r_state == IDLE);
   assign w_commit = w_wr_en && (dcr_wr_addr == DCR_COMMIT);

   assign dcr_wr_ready = (r_state == IDLE);
   assign admit_en     = (r_state == IDLE) && (r_cnt < MAX_CNT);
   assign dcrs         = r_active;
   assign cfg_busy     = r_busy;
   assign commit_done  = r_done;

   rop_dcr_decode u_decode (
      .i_wr_en    (w_wr_en),
      .i_wr_addr  (dcr_wr_addr),
      .i_wr_data  (dcr_wr_data),
`ifdef ROP_DCR_READBACK_EN
      .i_rd_addr  (dcr_rd_addr),
      .i_cfg_busy (r_busy),
      .o_rd_data  (dcr_rd_data),
`endif
      .i_staging  (r_staging),
      .o_staging  (w_staging_nxt)
   );

   // Saturate at both ends so a protocol slip cannot wrap the count
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (req_fire && !rsp_fire && r_cnt != MAX_CNT)
         w_cnt_nxt = r_cnt + CNT_BITS'(1);
      else if (rsp_fire && !req_fire && r_cnt != '0)
         w_cnt_nxt = r_cnt - CNT_BITS'(1);
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_commit) w_state_nxt = DRAIN;
         DRAIN:   if (w_cnt_nxt == '0) w_state_nxt = APPLY;
         APPLY:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= '0;
         r_staging <= ROP_DCRS_RESET;
         r_active  <= ROP_DCRS_RESET;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_cnt     <= w_cnt_nxt;
         r_staging <= rop_dcrs_t'(w_staging_nxt);
         if (r_state == APPLY) r_active <= r_staging;
         r_busy    <= (w_state_nxt != IDLE);
         r_done    <= (w_state_nxt == APPLY);
      end
   end

`ifndef SYNTHESIS
   a_rsp_underflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(rsp_fire && !req_fire && r_cnt == '0));
   a_req_blocked: assert property (@(posedge clk) disable iff (!reset_n)
      !(req_fire && !admit_en));
`endif

endmodule
